// File: rtl/pv_timing_pkg.sv
// Shared timing constants and meter state encoding for the pulse/usec timing blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pv_timing_pkg;

  localparam int unsigned USEC_PER_SEC = 1_000_000;
  localparam int          USEC_W       = 32;
  localparam int          DUTY_W       = 8;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARMED    = 2'd1,
    HIGH     = 2'd2
  } meter_state_t;

endpackage

// File: rtl/usec_tick_gen.sv
// Fractional accumulator producing a one-cycle tick per microsecond of sys_clk time.
// Latency: tick is combinational from the accumulator; phase is free-running from reset.
// Backpressure: none.
module usec_tick_gen (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] sys_clk_freq,
  output logic        tick
);
  import pv_timing_pkg::*;

  localparam logic [32:0] STEP = 33'(USEC_PER_SEC);

  logic [31:0] acc;
  logic [32:0] sum;

  always_comb begin
    sum  = {1'b0, acc} + STEP;
    tick = (sum >= {1'b0, sys_clk_freq});
  end

  // Below 1 MHz every cycle ticks; holding acc at 0 keeps it from creeping upward.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      acc <= '0;
    end else if (sys_clk_freq < USEC_PER_SEC) begin
      acc <= '0;
    end else if (tick) begin
      acc <= 32'(sum - {1'b0, sys_clk_freq});
    end else begin
      acc <= sum[31:0];
    end
  end

endmodule

// File: rtl/pulse_width_meter.sv
// Times high pulses on async pulse_in in usec; `PWM_PERIOD_EN adds period and duty (divider).
// Latency: width_valid SYNC_STAGES+2 cycles after pin fall; duty_valid ~41 cycles after a rise.
// Backpressure: none; strobes are fire-and-forget and results hold until the next strobe.
module pulse_width_meter
  import pv_timing_pkg::*;
#(
  parameter int unsigned TIMEOUT_USEC = 1_000_000,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [31:0]       sys_clk_freq,
  input  logic              pulse_in,
  output logic              busy,
  output logic              width_valid,
  output logic [USEC_W-1:0] usec_width,
  output logic              overflow,
  output logic [USEC_W-1:0] period_usec,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid
);

  localparam logic [USEC_W-1:0] TIMEOUT_W  = USEC_W'(TIMEOUT_USEC);
  localparam logic [USEC_W-1:0] TIMEOUT_M1 = USEC_W'(TIMEOUT_USEC - 1);

  logic tick;

  usec_tick_gen u_tick (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .sys_clk_freq (sys_clk_freq),
    .tick         (tick)
  );

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   prime_q;
  logic                   s, s_d, rise, fall, primed;

  // prime_q fills once s and s_d both carry post-reset samples of the pin, so a
  // pulse already high at reset release cannot masquerade as a fresh rise.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q  <= '0;
      s_d     <= 1'b0;
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      s_d     <= s;
      prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign rise   = s & ~s_d;
  assign fall   = ~s & s_d;
  assign primed = prime_q[SYNC_STAGES];

  meter_state_t      state_q, state_d;
  logic [USEC_W-1:0] cnt_q, cnt_d, width_q, width_d;
  logic              ovf_q, ovf_d, wv_q, wv_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= WAIT_LOW;
      cnt_q   <= '0;
      width_q <= '0;
      ovf_q   <= 1'b0;
      wv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      ovf_q   <= ovf_d;
      wv_q    <= wv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    ovf_d   = ovf_q;
    wv_d    = 1'b0;
    unique case (state_q)
      WAIT_LOW: if (primed && !s) state_d = ARMED;
      ARMED: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = '0;
        end
      end
      HIGH: begin
        // A fall coinciding with the timeout tick reports the real width.
        if (fall) begin
          state_d = ARMED;
          width_d = cnt_q;
          ovf_d   = 1'b0;
          wv_d    = 1'b1;
        end else if (tick && cnt_q == TIMEOUT_M1) begin
          state_d = WAIT_LOW;
          width_d = TIMEOUT_W;
          ovf_d   = 1'b1;
          wv_d    = 1'b1;
        end else if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  assign busy        = (state_q == HIGH);
  assign width_valid = wv_q;
  assign usec_width  = width_q;
  assign overflow    = ovf_q;

`ifdef PWM_PERIOD_EN
  logic              acc_rise;
  logic              p_run_q, div_busy_q, dv_q;
  logic [USEC_W-1:0] pcnt_q, period_q, divs_q, rem_q, rem_nxt;
  logic [39:0]       quo_q, quo_nxt;
  logic [32:0]       rem_sh;
  logic [5:0]        dcnt_q;
  logic [DUTY_W-1:0] duty_q;
  logic              ge;

  assign acc_rise = (state_q == ARMED) && rise;

  always_comb begin
    rem_sh  = {rem_q, quo_q[39]};
    ge      = (rem_sh >= {1'b0, divs_q});
    rem_nxt = ge ? 32'(rem_sh - {1'b0, divs_q}) : rem_sh[31:0];
    quo_nxt = {quo_q[38:0], ge};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      p_run_q    <= 1'b0;
      pcnt_q     <= '0;
      period_q   <= '0;
      divs_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dcnt_q     <= '0;
      div_busy_q <= 1'b0;
      duty_q     <= '0;
      dv_q       <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      if (state_q == WAIT_LOW) p_run_q <= 1'b0;
      else if (acc_rise)       p_run_q <= 1'b1;

      if (acc_rise)                         pcnt_q <= '0;
      else if (tick && pcnt_q != TIMEOUT_W) pcnt_q <= pcnt_q + 1'b1;

      // First rise after arming only starts the period count.
      if (acc_rise && p_run_q) begin
        period_q   <= pcnt_q;
        div_busy_q <= 1'b0;
        if (pcnt_q == '0) begin
          duty_q <= '1;
          dv_q   <= 1'b1;
        end else if (pcnt_q != TIMEOUT_W) begin
          quo_q      <= {width_q, 8'h00} - {8'h00, width_q};
          rem_q      <= '0;
          divs_q     <= pcnt_q;
          dcnt_q     <= '0;
          div_busy_q <= 1'b1;
        end
      end else if (div_busy_q) begin
        quo_q  <= quo_nxt;
        rem_q  <= rem_nxt;
        dcnt_q <= dcnt_q + 1'b1;
        if (dcnt_q == 6'd39) begin
          div_busy_q <= 1'b0;
          dv_q       <= 1'b1;
          duty_q     <= (quo_nxt > 40'd255) ? '1 : quo_nxt[DUTY_W-1:0];
        end
      end
    end
  end

  assign period_usec = period_q;
  assign duty        = duty_q;
  assign duty_valid  = dv_q;
`else
  assign period_usec = '0;
  assign duty        = '0;
  assign duty_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter: widths, timeout, reset behaviour, optional duty.
module tb_pulse_width_meter;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] sys_clk_freq = 32'd50_000_000;
  logic        pulse_in = 1'b0;
  logic        busy, width_valid, overflow, duty_valid;
  logic [31:0] usec_width, period_usec;
  logic [7:0]  duty;

  int checks = 0;
  int errors = 0;
  int wv_cnt = 0;
  int dv_cnt = 0;
  int base, dbase;

  always #10 sys_clk = ~sys_clk;

  pulse_width_meter #(.TIMEOUT_USEC(1000), .SYNC_STAGES(2)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .sys_clk_freq (sys_clk_freq),
    .pulse_in     (pulse_in),
    .busy         (busy),
    .width_valid  (width_valid),
    .usec_width   (usec_width),
    .overflow     (overflow),
    .period_usec  (period_usec),
    .duty         (duty),
    .duty_valid   (duty_valid)
  );

  always @(negedge sys_clk) begin
    if (width_valid) wv_cnt++;
    if (duty_valid)  dv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs,
                         input logic [31:0] lo, input logic [31:0] hi);
    logic in_rng;
    in_rng = (obs >= lo) && (obs <= hi);
    checks++;
    assert (in_rng === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    pulse_in = 1'b1;
    cyc(hi);
    pulse_in = 1'b0;
    cyc(lo);
  endtask

  initial begin
    // Reset state
    cyc(5);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wv", 32'(width_valid), 0);
    chk("rst_width", usec_width, 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_period", period_usec, 0);
    chk("rst_duty", 32'(duty), 0);
    chk("rst_dv", 32'(duty_valid), 0);
    sys_rst = 1'b0;
    cyc(20);

    // 1: 100 us pulse
    base = wv_cnt;
    pulse_in = 1'b1;
    cyc(2500);
    chk("t1_busy_mid", 32'(busy), 1);
    cyc(2500);
    pulse_in = 1'b0;
    cyc(10);
    chk("t1_strobes", 32'(wv_cnt - base), 1);
    chk_rng("t1_width", usec_width, 99, 101);
    chk("t1_ovf", 32'(overflow), 0);
    chk("t1_busy_after", 32'(busy), 0);

    // 2: timeout at 1000 us, no strobe at the late fall, then a 50 us pulse
    base = wv_cnt;
    pulse_in = 1'b1;
    cyc(55000);
    chk("t2_strobes", 32'(wv_cnt - base), 1);
    chk("t2_width", usec_width, 1000);
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_busy", 32'(busy), 0);
    cyc(5000);
    pulse_in = 1'b0;
    cyc(200);
    chk("t2_no_fall_strobe", 32'(wv_cnt - base), 1);
    base = wv_cnt;
    pulse(2500, 10);
    chk("t2b_strobes", 32'(wv_cnt - base), 1);
    chk_rng("t2b_width", usec_width, 49, 51);
    chk("t2b_ovf", 32'(overflow), 0);

    // 3: high through reset release is ignored, following 20 us pulse is measured
    sys_rst = 1'b1;
    pulse_in = 1'b1;
    cyc(4);
    sys_rst = 1'b0;
    base = wv_cnt;
    cyc(200);
    pulse_in = 1'b0;
    cyc(200);
    pulse(1000, 10);
    chk("t3_strobes", 32'(wv_cnt - base), 1);
    chk_rng("t3_width", usec_width, 19, 21);

    // 4: reset 40 us into a pulse discards it
    base = wv_cnt;
    pulse_in = 1'b1;
    cyc(2000);
    chk("t4_busy_mid", 32'(busy), 1);
    sys_rst = 1'b1;
    cyc(3);
    chk("t4_rst_busy", 32'(busy), 0);
    chk("t4_rst_width", usec_width, 0);
    chk("t4_rst_ovf", 32'(overflow), 0);
    sys_rst = 1'b0;
    cyc(500);
    chk("t4_not_rearmed", 32'(busy), 0);
    pulse_in = 1'b0;
    cyc(20);
    chk("t4_no_strobe", 32'(wv_cnt - base), 0);
    pulse(1500, 10);
    chk("t4_strobes", 32'(wv_cnt - base), 1);
    chk_rng("t4_width", usec_width, 29, 31);

    // 5: pulse shorter than one tick
    base = wv_cnt;
    pulse(10, 10);
    chk("t5_strobes", 32'(wv_cnt - base), 1);
    chk_rng("t5_width", usec_width, 0, 1);
    chk("t5_ovf", 32'(overflow), 0);

    // 6: 10 MHz clock, 25 us high / 75 us low, four rises
    sys_rst = 1'b1;
    sys_clk_freq = 32'd10_000_000;
    cyc(3);
    sys_rst = 1'b0;
    cyc(100);
    base  = wv_cnt;
    dbase = dv_cnt;
    repeat (3) pulse(250, 750);
    pulse_in = 1'b1;
    cyc(250);
    pulse_in = 1'b0;
    cyc(100);
    chk("t6_strobes", 32'(wv_cnt - base), 4);
    chk_rng("t6_width", usec_width, 24, 26);
`ifdef PWM_PERIOD_EN
    chk("t6_duty_strobes", 32'(dv_cnt - dbase), 3);
    chk_rng("t6_period", period_usec, 99, 101);
    chk_rng("t6_duty", 32'(duty), 62, 64);
`else
    chk("t6_duty_strobes", 32'(dv_cnt - dbase), 0);
    chk("t6_period", period_usec, 0);
    chk("t6_duty", 32'(duty), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
